// File: rtl/snn_window_scheduler.sv
// snn_window_scheduler
//   Runs one inference window over N_CH rate-coded accumulator neurons:
//   holds the per-channel weights, clears the neurons, enables them for
//   len cycles while counting spikes per channel, then walks the counters
//   one channel per cycle to find the argmax and reports it with a
//   one-cycle done pulse.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   cfg_valid/ready, cfg_ch, cfg_w
//                  weight write port; accepted only while idle
//   start, window_len
//                  begin a window of window_len cycles (idle only)
//   busy           high whenever not idle
//   neuron_rst     one-cycle clear to the neurons
//   neuron_en      neuron enable during the counting phase
//   w_bus          packed weights, channel i at [i*WIDTH +: WIDTH]
//   spike_in       per-neuron spike levels
//   done           one-cycle pulse, result valid
//   winner, winner_count, tie
//                  argmax result, held until the next done
module snn_window_scheduler #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int SPK_W = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(N_CH)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]          cfg_w,
  input  logic                      start,
  input  logic [CNT_W-1:0]          window_len,
  output logic                      busy,
  output logic                      neuron_rst,
  output logic                      neuron_en,
  output logic [N_CH*WIDTH-1:0]     w_bus,
  input  logic [N_CH-1:0]           spike_in,
  output logic                      done,
  output logic [$clog2(N_CH)-1:0]   winner,
  output logic [SPK_W-1:0]          winner_count,
  output logic                      tie
);

  localparam int CH_W = $clog2(N_CH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_RESOLVE,
    S_DONE
  } state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  len_reg;
  logic [CNT_W-1:0]  cyc_reg;
  logic [CH_W-1:0]   idx_reg;
  logic [SPK_W-1:0]  best_cnt_reg;
  logic [CH_W-1:0]   best_idx_reg;
  logic              tie_acc_reg;

  logic              cfg_ready_reg;
  logic              busy_reg;
  logic              neuron_rst_reg;
  logic              neuron_en_reg;
  logic              done_reg;
  logic [CH_W-1:0]   winner_reg;
  logic [SPK_W-1:0]  winner_count_reg;
  logic              tie_reg;

  logic [SPK_W-1:0]  cnt_reg [N_CH];
  logic [WIDTH-1:0]  w_reg   [N_CH];

  // One comparison per RESOLVE cycle: the candidate is the counter of the
  // channel currently addressed by idx_reg.
  logic [SPK_W-1:0]  cand;
  logic              cand_gt;
  logic              cand_eq;
  logic [SPK_W-1:0]  best_cnt_next;
  logic [CH_W-1:0]   best_idx_next;
  logic              tie_next;

  always_comb begin
    cand          = cnt_reg[idx_reg];
    cand_gt       = (cand > best_cnt_reg);
    cand_eq       = (cand == best_cnt_reg);
    best_cnt_next = best_cnt_reg;
    best_idx_next = best_idx_reg;
    tie_next      = tie_acc_reg;
    if (cand_gt) begin
      best_cnt_next = cand;
      best_idx_next = idx_reg;
      tie_next      = 1'b0;
    end else if (cand_eq) begin
      // Lower index stays the winner; an all-zero array ends up here too,
      // since the running best starts at 0.
      tie_next      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      len_reg          <= '0;
      cyc_reg          <= '0;
      idx_reg          <= '0;
      best_cnt_reg     <= '0;
      best_idx_reg     <= '0;
      tie_acc_reg      <= 1'b0;
      cfg_ready_reg    <= 1'b1;
      busy_reg         <= 1'b0;
      neuron_rst_reg   <= 1'b0;
      neuron_en_reg    <= 1'b0;
      done_reg         <= 1'b0;
      winner_reg       <= '0;
      winner_count_reg <= '0;
      tie_reg          <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            len_reg        <= window_len;
            state_reg      <= S_CLEAR;
            cfg_ready_reg  <= 1'b0;
            busy_reg       <= 1'b1;
            neuron_rst_reg <= 1'b1;
          end
        end
        S_CLEAR: begin
          cyc_reg        <= '0;
          idx_reg        <= '0;
          best_cnt_reg   <= '0;
          best_idx_reg   <= '0;
          tie_acc_reg    <= 1'b0;
          neuron_rst_reg <= 1'b0;
          if (len_reg == '0) begin
            state_reg     <= S_RESOLVE;
          end else begin
            state_reg     <= S_RUN;
            neuron_en_reg <= 1'b1;
          end
        end
        S_RUN: begin
          if (cyc_reg == len_reg - CNT_W'(1)) begin
            state_reg     <= S_RESOLVE;
            neuron_en_reg <= 1'b0;
          end else begin
            cyc_reg <= cyc_reg + CNT_W'(1);
          end
        end
        S_RESOLVE: begin
          best_cnt_reg <= best_cnt_next;
          best_idx_reg <= best_idx_next;
          tie_acc_reg  <= tie_next;
          if (idx_reg == CH_W'(N_CH - 1)) begin
            idx_reg          <= '0;
            state_reg        <= S_DONE;
            done_reg         <= 1'b1;
            winner_reg       <= best_idx_next;
            winner_count_reg <= best_cnt_next;
            tie_reg          <= tie_next;
          end else begin
            idx_reg <= idx_reg + CH_W'(1);
          end
        end
        S_DONE: begin
          state_reg     <= S_IDLE;
          busy_reg      <= 1'b0;
          cfg_ready_reg <= 1'b1;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  // Per-channel weight registers and saturating spike counters. An
  // out-of-range cfg_ch matches no channel, so the write is dropped while
  // the handshake still completes.
  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      always_ff @(posedge clk) begin
        if (rst) begin
          w_reg[gi] <= '0;
        end else if (cfg_valid && cfg_ready_reg && (cfg_ch == CH_W'(gi))) begin
          w_reg[gi] <= cfg_w;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg[gi] <= '0;
        end else if (state_reg == S_CLEAR) begin
          cnt_reg[gi] <= '0;
        end else if ((state_reg == S_RUN) && spike_in[gi] && (cnt_reg[gi] != '1)) begin
          cnt_reg[gi] <= cnt_reg[gi] + SPK_W'(1);
        end
      end

      assign w_bus[gi*WIDTH +: WIDTH] = w_reg[gi];
    end
  endgenerate

  assign cfg_ready    = cfg_ready_reg;
  assign busy         = busy_reg;
  assign neuron_rst   = neuron_rst_reg;
  assign neuron_en    = neuron_en_reg;
  assign done         = done_reg;
  assign winner       = winner_reg;
  assign winner_count = winner_count_reg;
  assign tie          = tie_reg;

endmodule

// File: tb/tb_snn_window_scheduler.sv
module tb_snn_window_scheduler;

  localparam int WIDTH = 8;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam int SPK_W = 12;
  localparam int CH_W  = $clog2(N_CH);
  localparam int SAT   = (1 << SPK_W) - 1;

  localparam int MODE_CONST = 0;
  localparam int MODE_RAND  = 1;
  localparam int MODE_T3    = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CH_W-1:0]        cfg_ch;
  logic [WIDTH-1:0]       cfg_w;
  logic                   start;
  logic [CNT_W-1:0]       window_len;
  logic                   busy;
  logic                   neuron_rst;
  logic                   neuron_en;
  logic [N_CH*WIDTH-1:0]  w_bus;
  logic [N_CH-1:0]        spike_in;
  logic                   done;
  logic [CH_W-1:0]        winner;
  logic [SPK_W-1:0]       winner_count;
  logic                   tie;

  int checks = 0;
  int errors = 0;

  // Reference state kept by the bench
  int w_model [N_CH];
  int dens    [N_CH];
  int exp_win, exp_cnt, exp_tie;
  int obs_win, obs_cnt, obs_tie;
  int last_done_k;

  always #5 clk = ~clk;

  snn_window_scheduler #(
    .WIDTH(WIDTH), .N_CH(N_CH), .CNT_W(CNT_W), .SPK_W(SPK_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_w(cfg_w),
    .start(start), .window_len(window_len),
    .busy(busy), .neuron_rst(neuron_rst), .neuron_en(neuron_en),
    .w_bus(w_bus), .spike_in(spike_in),
    .done(done), .winner(winner), .winner_count(winner_count), .tie(tie)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic logic [N_CH*WIDTH-1:0] packed_weights();
    logic [N_CH*WIDTH-1:0] v;
    for (int i = 0; i < N_CH; i++) v[i*WIDTH +: WIDTH] = WIDTH'(w_model[i]);
    return v;
  endfunction

  // Argmax from the counts: lowest index among the maxima; tie when the
  // maximum is shared or everything is zero.
  task automatic resolve_model(input int c [N_CH]);
    int mx, n;
    mx = 0;
    for (int i = 0; i < N_CH; i++) if (c[i] > mx) mx = c[i];
    exp_win = -1;
    n = 0;
    for (int i = 0; i < N_CH; i++) begin
      if (c[i] == mx) begin
        n++;
        if (exp_win < 0) exp_win = i;
      end
    end
    exp_cnt = mx;
    exp_tie = (n >= 2 || mx == 0) ? 1 : 0;
  endtask

  task automatic cfg_write(input int ch, input int w);
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_w     = WIDTH'(w);
    check("cfg_ready_idle", 32'(cfg_ready), 32'd1);
    @(posedge clk); #1;
    if (ch < N_CH) w_model[ch] = w & ((1 << WIDTH) - 1);
    cfg_valid = 1'b0;
  endtask

  // Runs one window from the current idle cycle. Cycle k counts from the
  // start-sampling cycle t (k=0): CLEAR at k=1, counting at k=2..len+1,
  // done expected at k=len+2+N_CH.
  task automatic run_window(input int len, input int mode, input logic [N_CH-1:0] pat,
                            input bit inject, input bit wr_start);
    int c [N_CH];
    int k, en_cycles, en_bad, rst_bad, busy_bad, w_bad, extra_done;
    bit got_done, in_run;
    logic [N_CH-1:0] sp;
    int wch, wv;
    for (int i = 0; i < N_CH; i++) c[i] = 0;
    en_cycles = 0; en_bad = 0; rst_bad = 0; busy_bad = 0; w_bad = 0; extra_done = 0;
    got_done = 0; last_done_k = -1;
    obs_win = -1; obs_cnt = -1; obs_tie = -1;

    start      = 1'b1;
    window_len = CNT_W'(len);
    if (wr_start) begin
      wch = int'($urandom_range(0, N_CH - 1));
      wv  = int'($urandom_range(0, 255));
      cfg_valid = 1'b1;
      cfg_ch    = CH_W'(wch);
      cfg_w     = WIDTH'(wv);
      w_model[wch] = wv;
    end
    @(posedge clk); #1;
    start = 1'b0;
    cfg_valid = 1'b0;
    k = 1;
    while (!got_done && k < len + N_CH + 20) begin
      in_run = (k >= 2 && k <= len + 1);
      if (neuron_en !== in_run) en_bad++;
      if (neuron_en === 1'b1) en_cycles++;
      if (neuron_rst !== (k == 1)) rst_bad++;
      if (busy !== 1'b1 || cfg_ready !== 1'b0) busy_bad++;
      if (w_bus !== packed_weights()) w_bad++;
      if (done === 1'b1) begin
        got_done = 1;
        last_done_k = k;
        obs_win = int'(winner);
        obs_cnt = int'(winner_count);
        obs_tie = int'(tie);
      end
      if (in_run) begin
        case (mode)
          MODE_CONST: sp = pat;
          MODE_T3: begin
            for (int i = 0; i < N_CH; i++) sp[i] = 1'b0;
            sp[0] = ((k - 2) < 30);
            sp[1] = (((k - 2) % 3) == 0);
            sp[2] = ((k - 2) < 10);
            sp[3] = ((k - 2) >= 34);
          end
          default: for (int i = 0; i < N_CH; i++) sp[i] = ($urandom_range(0, 7) < dens[i]);
        endcase
        for (int i = 0; i < N_CH; i++) if (sp[i] && c[i] < SAT) c[i]++;
      end else begin
        sp = N_CH'($urandom);
      end
      spike_in = sp;
      if (inject && !got_done) begin
        cfg_valid = 1'($urandom);
        cfg_ch    = CH_W'($urandom);
        cfg_w     = WIDTH'($urandom);
        start     = (k == 10) ? 1'b1 : 1'($urandom);
        window_len = CNT_W'($urandom_range(0, 3));
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    spike_in = '0;

    resolve_model(c);
    check("done_latency", 32'(last_done_k), 32'(len + 2 + N_CH));
    check("en_cycles", 32'(en_cycles), 32'(len));
    check("en_window_shape", 32'(en_bad), 32'd0);
    check("neuron_rst_shape", 32'(rst_bad), 32'd0);
    check("busy_ready_in_window", 32'(busy_bad), 32'd0);
    check("w_bus_stable", 32'(w_bad), 32'd0);
    check("winner", 32'(obs_win), 32'(exp_win));
    check("winner_count", 32'(obs_cnt), 32'(exp_cnt));
    check("tie", 32'(obs_tie), 32'(exp_tie));
    check("idle_after_done", 32'({busy, cfg_ready, done}), 32'b010);
    check("held_winner", 32'(winner), 32'(exp_win));
    if (inject) begin
      repeat (10) begin
        if (done === 1'b1 || busy === 1'b1) extra_done++;
        @(posedge clk); #1;
      end
      check("no_queued_start", 32'(extra_done), 32'd0);
    end
    $display("window len=%0d mode=%0d counts=%0d/%0d/%0d/%0d winner=%0d count=%0d tie=%0d done_k=%0d",
             len, mode, c[0], c[1], c[2], c[3], obs_win, obs_cnt, obs_tie, last_done_k);
  endtask

  initial begin
    int d;
    rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_w = '0;
    window_len = '0; spike_in = '0;
    for (int i = 0; i < N_CH; i++) begin w_model[i] = 0; dens[i] = 4; end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_neuron", 32'({neuron_en, neuron_rst}), 32'd0);
    check("rst_w_bus", w_bus, 32'd0);
    check("rst_result", 32'({winner, winner_count, tie}), 32'd0);

    // 1: weights then a constant single-channel spike train
    cfg_write(0, 10); cfg_write(1, 200); cfg_write(2, 50); cfg_write(3, 0);
    check("t1_w_bus", w_bus, 32'h0032C80A);
    run_window(100, MODE_CONST, 4'b0010, 0, 0);
    check("t1_latency", 32'(last_done_k), 32'd106);
    check("t1_result", 32'({obs_win[1:0], obs_cnt[11:0], obs_tie[0]}), {17'd0, 2'd1, 12'd100, 1'b0});

    // 2: saturation
    run_window(5000, MODE_CONST, 4'b0100, 0, 0);
    check("t2_result", 32'({obs_win[1:0], obs_cnt[11:0]}), {18'd0, 2'd2, 12'd4095});

    // 3: tie between ch0 and ch3
    run_window(64, MODE_T3, '0, 0, 0);
    check("t3_result", 32'({obs_win[1:0], obs_cnt[11:0], obs_tie[0]}), {17'd0, 2'd0, 12'd30, 1'b1});

    // 4: zero-length window
    run_window(0, MODE_RAND, '0, 0, 0);
    check("t4_latency", 32'(last_done_k), 32'd6);
    check("t4_result", 32'({obs_win[1:0], obs_cnt[11:0], obs_tie[0]}), {17'd0, 2'd0, 12'd0, 1'b1});

    // 5: config writes and start pulses while busy
    run_window(30, MODE_RAND, '0, 1, 0);
    check("t5_w_bus", w_bus, 32'h0032C80A);

    // 6: reset in the 40th counting cycle
    d = 0;
    start = 1'b1; window_len = 16'd100;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k < 41; k++) begin
      spike_in = N_CH'($urandom);
      if (done === 1'b1) d++;
      @(posedge clk); #1;
    end
    check("t6_pre_rst_en", 32'(neuron_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    spike_in = '0;
    for (int i = 0; i < N_CH; i++) w_model[i] = 0;
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_ready", 32'(cfg_ready), 32'd1);
    check("t6_neuron", 32'({neuron_en, neuron_rst}), 32'd0);
    check("t6_w_bus", w_bus, 32'd0);
    check("t6_result", 32'({winner, winner_count, tie}), 32'd0);
    repeat (8) begin
      if (done === 1'b1) d++;
      @(posedge clk); #1;
    end
    check("t6_no_done", 32'(d), 32'd0);
    run_window(20, MODE_CONST, 4'b1000, 0, 0);

    // Randomized windows, including a write coincident with start
    for (int n = 0; n < 10; n++) begin
      for (int j = int'($urandom_range(0, 3)); j > 0; j--)
        cfg_write(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 255)));
      for (int i = 0; i < N_CH; i++) dens[i] = int'($urandom_range(0, 2));
      run_window(int'($urandom_range(0, 60)), MODE_RAND, '0, 0, 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
